// File: rtl/uart_frame_rx_if.sv
// Serial receive bundle: the rx line in, and the assembled payload with its status pulses out.
interface uart_frame_rx_if #(
   parameter int PAYLOAD_W = 162
);
   logic                 rx_in;
   logic [PAYLOAD_W-1:0] data_out;
   logic                 ready;
   logic                 frame_err;
   logic                 parity_err;
   logic                 busy;

   modport master (
      output rx_in,
      input  data_out, ready, frame_err, parity_err, busy
   );

   modport slave (
      input  rx_in,
      output data_out, ready, frame_err, parity_err, busy
   );
endinterface

// File: rtl/uart_frame_rx.sv
// Multi-byte UART frame receiver: 3-sample majority vote, optional per-byte parity,
// stop-bit and inter-byte timeout checks; the payload is published only for clean frames.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line idle, waiting for the start edge of byte 0
// S_START | timing the start bit; a high vote is a false start
// S_DATA  | 8 data bits, LSB first, into the payload register
// S_PAR   | parity bit, mismatch latched for the whole frame
// S_STOP  | stop bit, decided mid-bit so the next start edge is caught
// S_GAP   | between bytes, inter-byte timeout running
module uart_frame_rx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int PAYLOAD_W    = 162,
   parameter int PARITY       = 0,
   parameter int GAP_BITS     = 20
) (
   input  logic            clk_in,
   input  logic            rst_in,
   uart_frame_rx_if.slave  bus
);

   localparam int NUM_BYTES = (PAYLOAD_W + 7) / 8;
   localparam int H         = CLKS_PER_BIT / 2;
   localparam int CNT_W     = $clog2(CLKS_PER_BIT);
   localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int IDX_W     = BYTE_W + 3;
   localparam int GAP_LIM   = GAP_BITS * CLKS_PER_BIT;
   localparam int GAP_W     = $clog2(GAP_LIM + 1);
   localparam bit ODD       = (PARITY == 2);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_GAP} state_t;

   state_t               r_state, w_state_nx;
   logic                 r_sync1, r_sync2, r_rxs_d;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_s0, r_s1;
   logic [2:0]           r_bit_idx;
   logic [BYTE_W-1:0]    r_byte_idx;
   logic [PAYLOAD_W-1:0] r_pay, r_data;
   logic                 r_xor, r_par_flag, r_from_gap;
   logic [GAP_W-1:0]     r_gap;
   logic                 r_ready, r_ferr, r_perr;

   logic                 w_fall, w_vote, w_mid, w_end, w_par_bad;
   logic [IDX_W-1:0]     w_idx;
   logic                 w_ready_set, w_ferr_set, w_perr_set, w_enter_start, w_byte_inc;

   // A falling edge needs rxs seen high first, so a line stuck low after a bad stop bit cannot restart a frame.
   assign w_fall    = r_rxs_d & ~r_sync2;
   assign w_vote    = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
   assign w_mid     = (r_cnt == CNT_W'(H + 1));
   assign w_end     = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign w_par_bad = r_xor ^ w_vote ^ ODD;
   assign w_idx     = {r_byte_idx, r_bit_idx};

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_rxs_d <= 1'b1;
      end else begin
         r_sync1 <= bus.rx_in;
         r_sync2 <= r_sync1;
         r_rxs_d <= r_sync2;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_cnt <= '0;
         r_s0  <= 1'b1;
         r_s1  <= 1'b1;
      end else begin
         if (r_state == S_IDLE || r_state == S_GAP || w_end) r_cnt <= '0;
         else                                                 r_cnt <= r_cnt + 1'b1;
         if (r_cnt == CNT_W'(H - 1)) r_s0 <= r_sync2;
         if (r_cnt == CNT_W'(H))     r_s1 <= r_sync2;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) r_state <= S_IDLE;
      else         r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx    = r_state;
      w_ready_set   = 1'b0;
      w_ferr_set    = 1'b0;
      w_perr_set    = 1'b0;
      w_enter_start = 1'b0;
      w_byte_inc    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_fall) begin
               w_state_nx    = S_START;
               w_enter_start = 1'b1;
            end
         end
         S_START: begin
            if (w_mid && w_vote) w_state_nx = r_from_gap ? S_GAP : S_IDLE;
            else if (w_end)      w_state_nx = S_DATA;
         end
         S_DATA: begin
            if (w_end && r_bit_idx == 3'd7) w_state_nx = (PARITY != 0) ? S_PAR : S_STOP;
         end
         S_PAR: begin
            if (w_end) w_state_nx = S_STOP;
         end
         S_STOP: begin
            if (w_mid) begin
               if (!w_vote) begin
                  w_ferr_set = 1'b1;
                  w_state_nx = S_IDLE;
               end else if (r_par_flag) begin
                  w_perr_set = 1'b1;
                  w_state_nx = S_IDLE;
               end else if (r_byte_idx == BYTE_W'(NUM_BYTES - 1)) begin
                  w_ready_set = 1'b1;
                  w_state_nx  = S_IDLE;
               end else begin
                  w_byte_inc = 1'b1;
                  w_state_nx = S_GAP;
               end
            end
         end
         S_GAP: begin
            // A start edge on the expiry cycle keeps the frame alive.
            if (w_fall) begin
               w_state_nx    = S_START;
               w_enter_start = 1'b1;
            end else if (r_gap == '0) begin
               w_ferr_set = 1'b1;
               w_state_nx = S_IDLE;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_bit_idx  <= '0;
         r_byte_idx <= '0;
         r_pay      <= '0;
         r_xor      <= 1'b0;
         r_par_flag <= 1'b0;
         r_from_gap <= 1'b0;
         r_gap      <= '0;
         r_data     <= '0;
         r_ready    <= 1'b0;
         r_ferr     <= 1'b0;
         r_perr     <= 1'b0;
      end else begin
         r_ready <= w_ready_set;
         r_ferr  <= w_ferr_set;
         r_perr  <= w_perr_set;
         if (w_ready_set) r_data <= r_pay;

         if (w_enter_start) begin
            r_bit_idx  <= '0;
            r_xor      <= 1'b0;
            r_from_gap <= (r_state == S_GAP);
            if (r_state == S_IDLE) begin
               r_byte_idx <= '0;
               r_pay      <= '0;
               r_par_flag <= 1'b0;
            end
         end

         if (r_state == S_DATA) begin
            if (w_mid) begin
               r_xor <= r_xor ^ w_vote;
               // Bits of the final byte beyond the payload width have no slot and fall away here.
               for (int p = 0; p < PAYLOAD_W; p++) begin
                  if (w_idx == IDX_W'(p)) r_pay[p] <= w_vote;
               end
            end
            if (w_end) r_bit_idx <= r_bit_idx + 1'b1;
         end

         if (r_state == S_PAR && w_mid && w_par_bad) r_par_flag <= 1'b1;

         if (w_byte_inc) begin
            r_byte_idx <= r_byte_idx + 1'b1;
            r_gap      <= GAP_W'(GAP_LIM - 1);
         end else if (r_state == S_GAP && !w_fall && r_gap != '0) begin
            r_gap <= r_gap - 1'b1;
         end
      end
   end

   assign bus.data_out   = r_data;
   assign bus.ready      = r_ready;
   assign bus.frame_err  = r_ferr;
   assign bus.parity_err = r_perr;
   assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: three instances cover the 16-bit no-parity frame,
// the default 162-bit width and even parity, all at 16 clocks per bit.
module tb_uart_frame_rx;
   localparam int CPB = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_frame_rx_if #(.PAYLOAD_W(16))  if0 ();
   uart_frame_rx_if #(.PAYLOAD_W(162)) if1 ();
   uart_frame_rx_if #(.PAYLOAD_W(8))   if2 ();

   uart_frame_rx #(.CLKS_PER_BIT(CPB), .PAYLOAD_W(16), .PARITY(0), .GAP_BITS(4))
      u_dut0 (.clk_in(clk), .rst_in(rst_n), .bus(if0));
   uart_frame_rx #(.CLKS_PER_BIT(CPB), .PAYLOAD_W(162), .PARITY(0), .GAP_BITS(20))
      u_dut1 (.clk_in(clk), .rst_in(rst_n), .bus(if1));
   uart_frame_rx #(.CLKS_PER_BIT(CPB), .PAYLOAD_W(8), .PARITY(1), .GAP_BITS(20))
      u_dut2 (.clk_in(clk), .rst_in(rst_n), .bus(if2));

   int n_cmp = 0;
   int n_err = 0;
   int n_rdy [3] = '{0, 0, 0};
   int n_fe  [3] = '{0, 0, 0};
   int n_pe  [3] = '{0, 0, 0};
   int n_wide = 0;
   int n_ovl  = 0;
   logic [2:0] prev [3] = '{3'b0, 3'b0, 3'b0};

   function automatic logic [2:0] pulses(input int ch);
      case (ch)
         0:       return {if0.ready, if0.frame_err, if0.parity_err};
         1:       return {if1.ready, if1.frame_err, if1.parity_err};
         default: return {if2.ready, if2.frame_err, if2.parity_err};
      endcase
   endfunction

   function automatic int busy_of(input int ch);
      case (ch)
         0:       return int'(if0.busy);
         1:       return int'(if1.busy);
         default: return int'(if2.busy);
      endcase
   endfunction

   function automatic int flags_of(input int ch);
      return int'({pulses(ch), 1'b0}) | busy_of(ch);
   endfunction

   function automatic logic [255:0] data_of(input int ch);
      logic [255:0] r = '0;
      case (ch)
         0:       r[15:0]  = if0.data_out;
         1:       r[161:0] = if1.data_out;
         default: r[7:0]   = if2.data_out;
      endcase
      return r;
   endfunction

   task automatic set_rx(input int ch, input logic v);
      case (ch)
         0:       if0.rx_in = v;
         1:       if1.rx_in = v;
         default: if2.rx_in = v;
      endcase
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_vec(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one character starting on a negedge; ev_j is the stop-bit cycle of the first status pulse (-1 if none).
   // gl_bit selects a bit position whose cycle 9 is inverted, which the DUT sees at its middle sample.
   task automatic send_byte(input int ch, input logic [7:0] d, input bit use_par, input logic par,
                            input logic stop, input int gl_bit, output int ev_j);
      logic bitv [0:10];
      int   nb;
      nb = use_par ? 11 : 10;
      bitv[0] = 1'b0;
      for (int i = 0; i < 8; i++) bitv[1+i] = d[i];
      bitv[9] = par;
      bitv[nb-1] = stop;
      ev_j = -1;
      for (int b = 0; b < nb; b++) begin
         for (int j = 0; j < CPB; j++) begin
            set_rx(ch, (b == gl_bit && j == 9) ? ~bitv[b] : bitv[b]);
            if (b == nb - 1 && ev_j < 0 && pulses(ch) != 3'b0) ev_j = j;
            @(negedge clk);
         end
      end
   endtask

   always @(posedge clk) begin
      logic [2:0] p;
      #1;
      for (int c = 0; c < 3; c++) begin
         p = pulses(c);
         n_rdy[c] += int'(p[2]);
         n_fe[c]  += int'(p[1]);
         n_pe[c]  += int'(p[0]);
         if ((p & prev[c]) != 3'b0) n_wide++;
         if ($countones(p) > 1) n_ovl++;
         prev[c] = p;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int j, w, rd_b, fe_b, pe_b;
      logic [255:0] e;
      logic [7:0]   bv;

      if0.rx_in = 1'b1;
      if1.rx_in = 1'b1;
      if2.rx_in = 1'b1;
      rst_n = 1'b0;
      idle(3);
      check_vec("rst_data0", data_of(0), 256'h0);
      check_int("rst_flags0", flags_of(0), 0);
      check_vec("rst_data1", data_of(1), 256'h0);
      rst_n = 1'b1;
      idle(4);

      // Two back-to-back bytes
      send_byte(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1, j);
      check_int("t1_byte0_no_pulse", j, -1);
      send_byte(0, 8'h3C, 1'b0, 1'b0, 1'b1, -1, j);
      check_int("t1_ready_latency", j, 13);
      check_vec("t1_data", data_of(0), 256'h3CA5);
      check_int("t1_ready_count", n_rdy[0], 1);
      check_int("t1_busy_after", busy_of(0), 0);

      // Bad stop bit followed by a line stuck low
      fe_b = n_fe[0];
      rd_b = n_rdy[0];
      send_byte(0, 8'h55, 1'b0, 1'b0, 1'b0, -1, j);
      check_int("t3_ferr_latency", j, 13);
      idle(48);
      check_int("t3_ferr_count", n_fe[0], fe_b + 1);
      check_int("t3_busy_low_line", busy_of(0), 0);
      set_rx(0, 1'b1);
      idle(32);
      check_int("t3_no_ready", n_rdy[0], rd_b);
      check_vec("t3_data_held", data_of(0), 256'h3CA5);
      send_byte(0, 8'h11, 1'b0, 1'b0, 1'b1, -1, j);
      send_byte(0, 8'h22, 1'b0, 1'b0, 1'b1, -1, j);
      check_vec("t3_recover_data", data_of(0), 256'h2211);

      // One-cycle glitch on an idle line
      rd_b = n_rdy[0] + n_fe[0] + n_pe[0];
      set_rx(0, 1'b0);
      idle(1);
      set_rx(0, 1'b1);
      idle(5);
      check_int("t4_busy_in_start", busy_of(0), 1);
      idle(20);
      check_int("t4_busy_back", busy_of(0), 0);
      check_int("t4_no_pulses", n_rdy[0] + n_fe[0] + n_pe[0], rd_b);

      // Mid-sample inversions are outvoted
      send_byte(0, 8'h5A, 1'b0, 1'b0, 1'b1, 4, j);
      send_byte(0, 8'hC3, 1'b0, 1'b0, 1'b1, 7, j);
      check_vec("t5_vote_data", data_of(0), 256'hC35A);

      // Inter-byte timeout with GAP_BITS=4
      fe_b = n_fe[0];
      rd_b = n_rdy[0];
      send_byte(0, 8'h77, 1'b0, 1'b0, 1'b1, -1, j);
      idle(40);
      check_int("t6_busy_in_gap", busy_of(0), 1);
      check_int("t6_no_early_ferr", n_fe[0], fe_b);
      w = 0;
      while (n_fe[0] == fe_b && w < 200) begin
         @(negedge clk);
         w++;
      end
      check_int("t6_timeout_ferr", n_fe[0], fe_b + 1);
      check_int("t6_timeout_window", int'(w >= 15 && w <= 30), 1);
      check_int("t6_busy_after", busy_of(0), 0);
      check_int("t6_no_ready", n_rdy[0], rd_b);
      send_byte(0, 8'h01, 1'b0, 1'b0, 1'b1, -1, j);
      idle(32);
      send_byte(0, 8'h80, 1'b0, 1'b0, 1'b1, -1, j);
      check_vec("t6_next_frame", data_of(0), 256'h8001);
      check_int("t6_next_ready", n_rdy[0], rd_b + 1);
      check_int("t6_gap_ok_no_ferr", n_fe[0], fe_b + 1);

      // Default width: 21 bytes, last one 0xFF
      rd_b = n_rdy[1];
      e = '0;
      for (int k = 0; k < 21; k++) begin
         bv = (k == 20) ? 8'hFF : 8'(k * 37 + 5);
         if (k < 20) e[8*k +: 8] = bv;
         send_byte(1, bv, 1'b0, 1'b0, 1'b1, -1, j);
      end
      e[161:160] = 2'b11;
      check_int("t2_ready_latency", j, 13);
      check_vec("t2_wide_data", data_of(1), e);
      check_int("t2_ready_count", n_rdy[1], rd_b + 1);
      check_int("t2_busy_after", busy_of(1), 0);

      // Even parity
      rd_b = n_rdy[2];
      pe_b = n_pe[2];
      send_byte(2, 8'h42, 1'b1, 1'b0, 1'b1, -1, j);
      check_int("t7_good_latency", j, 13);
      check_vec("t7_good_data", data_of(2), 256'h42);
      send_byte(2, 8'h07, 1'b1, 1'b0, 1'b1, -1, j);
      check_int("t7_perr_latency", j, 13);
      check_int("t7_perr_count", n_pe[2], pe_b + 1);
      check_int("t7_perr_no_ready", n_rdy[2], rd_b + 1);
      check_vec("t7_perr_data_held", data_of(2), 256'h42);
      send_byte(2, 8'h07, 1'b1, 1'b1, 1'b1, -1, j);
      check_vec("t7_fixed_data", data_of(2), 256'h07);
      check_int("t7_fixed_ready", n_rdy[2], rd_b + 2);
      check_int("t7_no_extra_perr", n_pe[2], pe_b + 1);

      // Reset in the middle of byte 1
      fe_b = n_fe[0] + n_pe[0];
      rd_b = n_rdy[0];
      send_byte(0, 8'h99, 1'b0, 1'b0, 1'b1, -1, j);
      set_rx(0, 1'b0);
      idle(CPB);
      set_rx(0, 1'b1);
      idle(40);
      check_int("t8_busy_mid_byte", busy_of(0), 1);
      rst_n = 1'b0;
      #1;
      check_vec("t8_rst_data", data_of(0), 256'h0);
      check_int("t8_rst_flags", flags_of(0), 0);
      idle(3);
      rst_n = 1'b1;
      idle(20);
      send_byte(0, 8'h34, 1'b0, 1'b0, 1'b1, -1, j);
      send_byte(0, 8'h12, 1'b0, 1'b0, 1'b1, -1, j);
      check_vec("t8_after_reset_data", data_of(0), 256'h1234);
      check_int("t8_after_reset_ready", n_rdy[0], rd_b + 1);
      check_int("t8_no_error_pulse", n_fe[0] + n_pe[0], fe_b);

      idle(4);
      check_int("pulse_width", n_wide, 0);
      check_int("pulse_exclusive", n_ovl, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Parametrised successor to the fixed-width serial frame receiver.
- Assembles a multi-byte UART frame into a wide payload word. Width, baud divisor and parity mode are configurable.
- Adds 3-sample majority voting, parity checking, framing-error and inter-byte-timeout detection.
- Sits between the board rx pin and game logic; payload is delivered only for error-free frames.

Parameters:
- CLKS_PER_BIT, 868, clk_in cycles per serial bit (>= 8).
- PAYLOAD_W, 162, payload width in bits. NUM_BYTES = ceil(PAYLOAD_W/8) is a derived localparam.
- PARITY, 0, 0 = none, 1 = even, 2 = odd; one parity bit per byte after the data bits.
- GAP_BITS, 20, maximum idle bit-times between the stop bit of one byte and the start bit of the next within a frame.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset (0 = reset).
- rx_in  input  1  asynchronous serial line, idle high.
- data_out  output  PAYLOAD_W  last good frame payload.
- ready  output  1  one-cycle pulse: data_out just updated.
- frame_err  output  1  one-cycle pulse: bad stop bit or inter-byte timeout.
- parity_err  output  1  one-cycle pulse: parity mismatch.
- busy  output  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Reset (rst_in = 0, async):
  - data_out = 0; ready = frame_err = parity_err = busy = 0.
  - 2-FF synchroniser flops = 1; state = IDLE; byte/bit/timer counters = 0.
  - A reset mid-frame discards the partial frame with no error pulse.
- Input path: rx_in passes through the 2-FF synchroniser (rxs). Start detection uses the registered falling edge of rxs.
- Bit timing:
  - The cycle counter is cleared on the falling-edge cycle and counts 0..CLKS_PER_BIT-1 per bit.
  - With H = CLKS_PER_BIT/2, rxs is sampled at counts H-1, H and H+1. The bit value is the majority of the three samples, decided at count H+1.
- States: IDLE, START, DATA, PAR, STOP, GAP.
  - IDLE: falling edge -> START; byte index = 0; shift register cleared.
  - START: vote = 0 -> DATA at the next bit boundary. Vote = 1 is a false start: return to the entry state (IDLE or GAP, with GAP timer preserved), no error.
  - DATA: 8 bits, LSB first. Byte k bit i goes to payload bit 8k+i; bits at or above PAYLOAD_W are discarded. After bit 7 -> PAR if PARITY != 0, else STOP.
  - PAR: the vote is checked against the XOR of the 8 data bits (even: XOR^par = 0; odd: XOR^par = 1). A mismatch latches a per-frame parity flag. Then -> STOP.
  - STOP: decided at count H+1, with no wait for the bit end.
    - Vote = 0: frame_err pulse on the next cycle; frame discarded; -> IDLE. New start edges are ignored until rxs has been seen high.
    - Vote = 1, parity flag set: parity_err pulse on the next cycle; frame discarded; -> IDLE.
    - Vote = 1, last byte (index NUM_BYTES-1): data_out <= assembled payload and ready = 1 on the next cycle; -> IDLE.
    - Vote = 1, otherwise: byte index + 1; -> GAP.
  - GAP:
    - Falling edge -> START.
    - The timer counts cycles. When it reaches GAP_BITS*CLKS_PER_BIT, frame_err pulses, the frame is discarded and state -> IDLE.
    - A falling edge on the same cycle as expiry wins: the frame continues, no error.
- Output rules:
  - Latency from the final stop-bit decision to ready is 1 cycle.
  - Pulses are exactly 1 cycle wide and mutually exclusive.
  - data_out is unchanged on any error and holds until the next good frame.
- Back-to-back bytes with a single stop bit must be received with no loss. The STOP decision at H+1 leaves half a bit to catch the next start edge.

Test Plan:
- Good frame, no parity. CLKS_PER_BIT=16, PAYLOAD_W=16, PARITY=0. Send bytes 0xA5 then 0x3C back-to-back -> data_out=16'h3CA5, ready one pulse 1 cycle after the second stop decision; busy low afterwards.
- Default width. PAYLOAD_W=162, 21 bytes, last byte 0xFF -> data_out[161:160]=2'b11, upper 6 bits of byte 20 ignored, one ready pulse.
- Parity. PARITY=1. Send 0x07 with parity bit 0 (wrong) -> parity_err pulse only, no ready, data_out unchanged. Repeat with parity 1 -> ready pulse.
- Framing and glitches:
  - Stop bit forced 0 -> frame_err pulse; line held low 3 bit-times -> no new frame accepted until the line is high.
  - Single-cycle low glitch on an idle line -> false start, no pulses, busy returns to 0.
- Noise and timeout:
  - One-cycle inversion at count H of a data bit -> the majority vote yields the correct byte.
  - GAP_BITS=4, first byte sent, then idle for 4*16 cycles -> frame_err pulse, next full frame received correctly.
- Reset. Assert rst_in low in the middle of byte 1 -> all outputs 0 immediately; a subsequent full frame is received correctly.
